// File: rtl/mmio_timer.sv
// Purpose: memory-mapped 64-bit machine timer (mtime/cmp/ctrl/status) answering a 32-byte bus window.
// Latency: reads are combinational from a; writes land at the clock edge where we & hit; irq follows pending combinationally.
// Backpressure: none; every access completes in its own cycle and the responder never stalls the core.
//
// Ports:
//   clk, clr        clock (rising edge) and asynchronous active-low reset
//   we, byteEnable  write strobe and per-byte write lanes (bit i -> wd[8i+7:8i])
//   a, wd           byte address and write data
//   rd, hit         combinational read data and window-decode flag
//   irq             level interrupt = pending & CTRL.IE
//
// Build option: define MMIO_TIMER_PRESCALER_EN to implement the prescaler and the CTRL.PRESC field;
// without it mtime advances every enabled cycle and CTRL[15:8] reads 0.

module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          PRESC_W   = 8
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        we,
    input  logic [3:0]  byteEnable,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        hit,
    output logic        irq
);

    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_STATUS   = 3'd5;

    logic [63:0] mtime;
    logic [63:0] cmp;
    logic        en;
    logic        ie;
    logic        pending;
    logic        tick;
    logic [31:0] presc_rd;

    logic [2:0]  off;
    logic        wr;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        match;

    // a[1:0] carry no information for word registers
    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, a[1:0]};

    assign off = a[4:2];
    assign hit = (a[31:5] == BASE_ADDR[31:5]);

    // A write with no lanes enabled is treated as no write at all, so it
    // neither stalls mtime nor restarts the prescaler.
    assign wr          = we & hit & (|byteEnable);
    assign wr_mtime_lo = wr & (off == OFF_MTIME_LO);
    assign wr_mtime_hi = wr & (off == OFF_MTIME_HI);

    assign match = (mtime >= cmp);
    assign irq   = pending & ie;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

`ifdef MMIO_TIMER_PRESCALER_EN
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] pcnt;

    // mtime advances on the cycle the count has reached PRESC, i.e. once
    // every PRESC+1 enabled cycles.
    assign tick     = (pcnt == presc);
    assign presc_rd = {{(24 - PRESC_W){1'b0}}, presc, 8'h00};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pcnt <= '0;
        end else if (wr_mtime_lo || wr_mtime_hi) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc <= '0;
        end else if (wr && (off == OFF_CTRL) && byteEnable[1]) begin
            presc <= wd[8 +: PRESC_W];
        end
    end
`else
    assign tick     = 1'b1;
    assign presc_rd = 32'h0;
`endif

    // A software write to either half takes priority over counting for that edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mtime <= 64'h0;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= lane_merge(mtime[31:0], wd, byteEnable);
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= lane_merge(mtime[63:32], wd, byteEnable);
        end else if (en && tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cmp <= '1;
        end else if (wr && (off == OFF_CMP_LO)) begin
            cmp[31:0] <= lane_merge(cmp[31:0], wd, byteEnable);
        end else if (wr && (off == OFF_CMP_HI)) begin
            cmp[63:32] <= lane_merge(cmp[63:32], wd, byteEnable);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            en <= 1'b0;
            ie <= 1'b0;
        end else if (wr && (off == OFF_CTRL) && byteEnable[0]) begin
            en <= wd[0];
            ie <= wd[1];
        end
    end

    // Set has priority over write-1-to-clear so a clear racing a live match
    // cannot lose the interrupt.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pending <= 1'b0;
        end else if (match) begin
            pending <= 1'b1;
        end else if (wr && (off == OFF_STATUS) && byteEnable[0] && wd[0]) begin
            pending <= 1'b0;
        end
    end

    always_comb begin
        rd = 32'h0;
        if (hit) begin
            case (off)
                OFF_MTIME_LO: rd = mtime[31:0];
                OFF_MTIME_HI: rd = mtime[63:32];
                OFF_CMP_LO:   rd = cmp[31:0];
                OFF_CMP_HI:   rd = cmp[63:32];
                OFF_CTRL:     rd = presc_rd | {30'h0, ie, en};
                OFF_STATUS:   rd = {31'h0, pending};
                default:      rd = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        clr;
    logic        we;
    logic [3:0]  byteEnable;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        hit;
    logic        irq;

    int total = 0;
    int bad   = 0;

    mmio_timer #(.BASE_ADDR(BASE), .PRESC_W(8)) dut (
        .clk        (clk),
        .clr        (clr),
        .we         (we),
        .byteEnable (byteEnable),
        .a          (a),
        .wd         (wd),
        .rd         (rd),
        .hit        (hit),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_en;
    logic        m_ie;
    logic        m_pend;
`ifdef MMIO_TIMER_PRESCALER_EN
    logic [7:0]  m_presc;
    int          m_since;   // enabled cycles elapsed since the last mtime step
`endif

    task automatic model_reset();
        m_mtime = 64'h0;
        m_cmp   = {64{1'b1}};
        m_en    = 1'b0;
        m_ie    = 1'b0;
        m_pend  = 1'b0;
`ifdef MMIO_TIMER_PRESCALER_EN
        m_presc = 8'h0;
        m_since = 0;
`endif
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mread(input logic [31:0] addr);
        if (addr[31:5] != BASE[31:5]) return 32'h0;
        case (addr[4:2])
            3'd0: return m_mtime[31:0];
            3'd1: return m_mtime[63:32];
            3'd2: return m_cmp[31:0];
            3'd3: return m_cmp[63:32];
`ifdef MMIO_TIMER_PRESCALER_EN
            3'd4: return {16'h0, m_presc, 6'h0, m_ie, m_en};
`else
            3'd4: return {30'h0, m_ie, m_en};
`endif
            3'd5: return {31'h0, m_pend};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge();
        logic       w;
        logic [2:0] o;
        logic       was_match;
        w         = we && (a[31:5] == BASE[31:5]) && (byteEnable != 4'h0);
        o         = a[4:2];
        was_match = (m_mtime >= m_cmp);
        if (w && o == 3'd0) begin
            m_mtime[31:0] = lanes(m_mtime[31:0], wd, byteEnable);
`ifdef MMIO_TIMER_PRESCALER_EN
            m_since = 0;
`endif
        end else if (w && o == 3'd1) begin
            m_mtime[63:32] = lanes(m_mtime[63:32], wd, byteEnable);
`ifdef MMIO_TIMER_PRESCALER_EN
            m_since = 0;
`endif
        end else if (m_en) begin
`ifdef MMIO_TIMER_PRESCALER_EN
            if (m_since == int'(m_presc)) begin
                m_since = 0;
                m_mtime = m_mtime + 64'd1;
            end else begin
                m_since = m_since + 1;
            end
`else
            m_mtime = m_mtime + 64'd1;
`endif
        end
        if (w && o == 3'd2) m_cmp[31:0]  = lanes(m_cmp[31:0], wd, byteEnable);
        if (w && o == 3'd3) m_cmp[63:32] = lanes(m_cmp[63:32], wd, byteEnable);
        if (w && o == 3'd4) begin
            if (byteEnable[0]) begin
                m_en = wd[0];
                m_ie = wd[1];
            end
`ifdef MMIO_TIMER_PRESCALER_EN
            if (byteEnable[1]) m_presc = wd[15:8];
`endif
        end
        if (was_match) m_pend = 1'b1;
        else if (w && o == 3'd5 && byteEnable[0] && wd[0]) m_pend = 1'b0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge clr);
            if (!clr) model_reset();
            else model_edge();
        end
    end

    // ---------------- stimulus helpers (low clock phase) ----------------
    task automatic wr(input logic [2:0] off, input logic [3:0] be, input logic [31:0] d);
        we = 1'b1; a = BASE + {27'h0, off, 2'b00}; byteEnable = be; wd = d;
        @(negedge clk);
        we = 1'b0; byteEnable = 4'h0;
    endtask

    task automatic put(input logic [31:0] addr);
        we = 1'b0; byteEnable = 4'h0; a = addr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
    endtask

    function automatic logic [31:0] off_addr(input int off);
        logic [2:0] o;
        o = off[2:0];
        return BASE + {27'h0, o, 2'b00};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] exp_r [8];
        exp_r = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            put(off_addr(i));
            total++;
            if (rd !== exp_r[i]) begin bad++; $display("FAIL reset_rd_off%0d: got %h want %h", i, rd, exp_r[i]); end
        end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
        put(BASE + 32'h20);
        total++;
        if (hit !== 1'b0) begin bad++; $display("FAIL out_of_window_hit: got %b want 0", hit); end
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL out_of_window_rd: got %h want 0", rd); end
        @(negedge clk);
    endtask

    task automatic test_prescaler();
        logic [31:0] exp_lo, exp_ctrl;
`ifdef MMIO_TIMER_PRESCALER_EN
        exp_lo = 32'd5; exp_ctrl = 32'h0000_0301;
`else
        exp_lo = 32'd20; exp_ctrl = 32'h0000_0001;
`endif
        wr(3'd4, 4'hF, 32'h0000_0301);
        repeat (20) @(negedge clk);
        put(off_addr(0));
        total++;
        if (rd !== exp_lo) begin bad++; $display("FAIL presc_mtime_lo: got %0d want %0d", rd, exp_lo); end
        put(off_addr(4));
        total++;
        if (rd !== exp_ctrl) begin bad++; $display("FAIL presc_ctrl: got %h want %h", rd, exp_ctrl); end
        wr(3'd4, 4'hF, 32'h0);
    endtask

    task automatic test_wrap();
        wr(3'd0, 4'hF, 32'hFFFF_FFFE);
        wr(3'd1, 4'hF, 32'hFFFF_FFFF);
        wr(3'd4, 4'hF, 32'h0000_0001);
        @(negedge clk);
        put(off_addr(0));
        total++;
        if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap1_lo: got %h want ffffffff", rd); end
        put(off_addr(1));
        total++;
        if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap1_hi: got %h want ffffffff", rd); end
        @(negedge clk);
        put(off_addr(0));
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL wrap2_lo: got %h want 0", rd); end
        put(off_addr(1));
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL wrap2_hi: got %h want 0", rd); end
        wr(3'd4, 4'hF, 32'h0);
    endtask

    task automatic test_byte_lanes();
        do_reset();
        wr(3'd2, 4'b0101, 32'h1122_3344);
        put(off_addr(2));
        total++;
        if (rd !== 32'hFF22_FF44) begin bad++; $display("FAIL lanes_cmp_lo: got %h want ff22ff44", rd); end
        wr(3'd3, 4'b0000, 32'h0);
        wr(3'd0, 4'b0000, 32'h1234_5678);
        put(off_addr(3));
        total++;
        if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL lanes_be0_cmp_hi: got %h want ffffffff", rd); end
        put(off_addr(0));
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL lanes_be0_mtime_lo: got %h want 0", rd); end
        @(negedge clk);
    endtask

    task automatic test_irq();
        logic found;
        found = 1'b0;
        do_reset();
        wr(3'd3, 4'hF, 32'h0);
        wr(3'd2, 4'hF, 32'd10);
        wr(3'd4, 4'hF, 32'h3);
        for (int i = 0; i < 60 && !found; i++) begin
            put(off_addr(0));
            if (rd == 32'd10) begin
                found = 1'b1;
                put(off_addr(5));
                total++;
                if (rd !== 32'h0 || irq !== 1'b0) begin
                    bad++; $display("FAIL irq_before: status %h irq %b want 0 0", rd, irq);
                end
                @(negedge clk);
                put(off_addr(5));
                total++;
                if (rd !== 32'h1 || irq !== 1'b1) begin
                    bad++; $display("FAIL irq_after: status %h irq %b want 1 1", rd, irq);
                end
            end else begin
                @(negedge clk);
            end
        end
        total++;
        if (!found) begin bad++; $display("FAIL irq_reach10: got no match want mtime 10 within budget"); end
        wr(3'd5, 4'h1, 32'h1);
        put(off_addr(5));
        total++;
        if (rd !== 32'h1 || irq !== 1'b1) begin bad++; $display("FAIL irq_w1c_set_wins: status %h irq %b want 1 1", rd, irq); end
        wr(3'd2, 4'hF, 32'd1000);
        wr(3'd5, 4'h1, 32'h1);
        put(off_addr(5));
        total++;
        if (rd !== 32'h0 || irq !== 1'b0) begin bad++; $display("FAIL irq_cleared: status %h irq %b want 0 0", rd, irq); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        wr(3'd2, 4'hF, 32'd5);
        repeat (4) @(negedge clk);
        #1;
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL async_pre_irq: got %b want 1", irq); end
        @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL async_irq: got %b want 0", irq); end
        put(off_addr(0));
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL async_mtime_lo: got %h want 0", rd); end
        put(off_addr(2));
        total++;
        if (rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL async_cmp_lo: got %h want ffffffff", rd); end
        put(off_addr(4));
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL async_ctrl: got %h want 0", rd); end
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] exp_rd;
        logic        exp_hit, exp_irq;
        int          off;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            off = $urandom_range(0, 7);
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = off_addr(off) | {30'h0, 2'($urandom_range(0, 3))};
            we         = ($urandom_range(0, 1) == 1);
            byteEnable = 4'($urandom_range(0, 15));
            wd         = $urandom;
            if (a[4:2] == 3'd3) wd = $urandom_range(0, 1);
            if (a[4:2] == 3'd4 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
            #1;
            exp_rd  = mread(a);
            exp_hit = (a[31:5] == BASE[31:5]);
            exp_irq = m_pend & m_ie;
            total++;
            if (rd !== exp_rd) begin bad++; $display("FAIL rand_rd[%0d] a=%h: got %h want %h", n, a, rd, exp_rd); end
            total++;
            if (hit !== exp_hit) begin bad++; $display("FAIL rand_hit[%0d] a=%h: got %b want %b", n, a, hit, exp_hit); end
            total++;
            if (irq !== exp_irq) begin bad++; $display("FAIL rand_irq[%0d]: got %b want %b", n, irq, exp_irq); end
            @(negedge clk);
        end
        we = 1'b0;
        byteEnable = 4'h0;
    endtask

    initial begin
        clr = 1'b0; we = 1'b0; byteEnable = 4'h0; a = BASE; wd = 32'h0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        test_reset();
        test_prescaler();
        test_wrap();
        test_byte_lanes();
        test_irq();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
